// File: rtl/pulse_receiver_symbol_decoder.sv
// Pulse-width symbol decoder.
// Each pulse becomes a 2-bit symbol {level, long}. Symbols are packed into 16-symbol words,
// and completed words are queued in a small FIFO. A frame starts on an edge away from the
// idle level and ends after the line has sat at the idle level for `timeout` ticks.
module pulse_receiver_symbol_decoder #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             sig_in,
    input  logic             invert,
    input  logic             idle_level,
    input  logic [3:0]       prescaler,
    input  logic [CNT_W-1:0] threshold,
    input  logic [CNT_W-1:0] timeout,
    input  logic             rd_en,
    output logic [31:0]      word_data,
    output logic [4:0]       word_count,
    output logic             word_valid,
    output logic             frame_done,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t             state_q;
    logic               lvl_q;
    logic [15:0]        psc_q;
    logic [CNT_W-1:0]   width_q;
    logic [3:0]         sym_idx_q;
    logic [31:0]        asm_q;

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]  fill_q;
    logic [31:0]        data_mem [FIFO_DEPTH];
    logic [4:0]         cnt_mem  [FIFO_DEPTH];

    logic               lvl, edge_det, tick, width_sat;
    logic [15:0]        psc_limit;
    logic [1:0]         sym;
    logic               emit, timeout_hit, push_full, push_part, push, pop, full, push_ok;
    logic [31:0]        push_data;
    logic [4:0]         push_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign lvl       = sig_in ^ invert;
    assign edge_det  = en && (lvl != lvl_q);
    assign psc_limit = (16'd1 << prescaler) - 16'd1;
    // >= rather than == so a live prescaler decrease cannot strand the counter past the limit
    assign tick      = en && (psc_q >= psc_limit);
    assign width_sat = (width_q == {CNT_W{1'b1}});
    assign sym       = {lvl_q, (width_q > threshold)};

    assign emit        = (state_q == StActive) && edge_det;
    assign timeout_hit = en && (state_q == StActive) && (timeout != '0) && (lvl_q == idle_level)
                         && !edge_det && (width_q >= timeout);
    assign push_full   = emit && (sym_idx_q == 4'd15);
    assign push_part   = timeout_hit && (sym_idx_q != 4'd0);
    assign push        = !clear && (push_full || push_part);
    assign push_data   = push_full ? {sym, asm_q[29:0]} : asm_q;
    assign push_count  = push_full ? 5'd16 : {1'b0, sym_idx_q};

    assign word_valid  = (fill_q != '0);
    assign full        = (fill_q == FILL_W'(FIFO_DEPTH));
    assign pop         = !clear && rd_en && word_valid;
    // A full FIFO still accepts a push when the head is being popped in the same cycle
    assign push_ok     = push && (!full || pop);

    assign word_data   = word_valid ? data_mem[rd_ptr_q] : '0;
    assign word_count  = word_valid ? cnt_mem[rd_ptr_q] : '0;
    assign busy        = (state_q == StActive);

    // Frame FSM with line tracking, prescaler, width counter and symbol assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lvl_q      <= 1'b0;
            psc_q      <= '0;
            width_q    <= '0;
            sym_idx_q  <= '0;
            asm_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            lvl_q      <= lvl;
            frame_done <= 1'b0;
            if (clear || !en) begin
                state_q   <= StIdle;
                psc_q     <= '0;
                width_q   <= '0;
                sym_idx_q <= '0;
                asm_q     <= '0;
            end else begin
                if (edge_det) begin
                    psc_q   <= '0;
                    width_q <= '0;
                end else begin
                    psc_q <= tick ? 16'd0 : psc_q + 16'd1;
                    if (tick && !width_sat) begin
                        width_q <= width_q + CNT_W'(1);
                    end
                end
                case (state_q)
                    StIdle: begin
                        if (edge_det && (lvl_q == idle_level)) begin
                            state_q <= StActive;
                        end
                    end
                    StActive: begin
                        if (emit) begin
                            if (sym_idx_q == 4'd15) begin
                                sym_idx_q <= '0;
                                asm_q     <= '0;
                            end else begin
                                asm_q[{sym_idx_q, 1'b0} +: 2] <= sym;
                                sym_idx_q                     <= sym_idx_q + 4'd1;
                            end
                        end else if (timeout_hit) begin
                            state_q    <= StIdle;
                            sym_idx_q  <= '0;
                            asm_q      <= '0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // FIFO pointers, fill level and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end else if (push) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            fill_q <= fill_q + FILL_W'(push_ok) - FILL_W'(pop);
        end
    end

    // FIFO storage; contents are masked at the outputs while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_q] <= push_data;
            cnt_mem[wr_ptr_q]  <= push_count;
        end
    end

endmodule
